// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap sequencer: CSR addresses, cause codes,
// mstatus field positions, FSM states and the mstatus update helpers.
package trap_ctrl_pkg;

  typedef enum logic [11:0] {
    CSR_MSTATUS = 12'h300,
    CSR_MTVEC   = 12'h305,
    CSR_MEPC    = 12'h341,
    CSR_MCAUSE  = 12'h342
  } csr_addr_e;

  localparam logic [31:0] CAUSE_ECALL     = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK    = 32'd3;
  localparam logic [31:0] CAUSE_IRQ_EXT   = 32'h8000_000B;
  localparam logic [31:0] CAUSE_IRQ_TIMER = 32'h8000_0007;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_MTVEC,
    ST_COMMIT,
    ST_MRET
  } trap_state_e;

  function automatic logic [31:0] mstatus_on_trap(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    r[MSTATUS_MPIE] = s[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  function automatic logic [31:0] mstatus_on_mret(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/trap_ctrl_irq_sync.sv
// Interrupt-level synchronizer: N-deep flop chain cleared by synchronous reset;
// N = 0 is a straight wire.
module irq_sync #(
  parameter int unsigned N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  if (N == 0) begin : g_bypass
    logic unused_bypass;
    assign unused_bypass = clk ^ rst_n;
    assign q = d;
  end else begin : g_chain
    logic [N-1:0] chain;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        chain <= '0;
      end else begin
        chain[0] <= d;
        for (int unsigned i = 1; i < N; i++) begin
          chain[i] <= chain[i-1];
        end
      end
    end

    assign q = chain[N-1];
  end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: takes ecall/ebreak/irqs via mtvec fetch and single-cycle
// CSR commit, handles mret, arbitrates the CSR read port. Option: TRAP_VECTORED_EN.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int unsigned IRQ_SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_ecall,
  input  logic        ex_ebreak,
  input  logic        ex_mret,
  input  logic [31:0] ex_pc,
  input  logic        irq_timer,
  input  logic        irq_ext,
  input  logic [11:0] ex_csr_rdaddr,
  output logic [11:0] csr_rdaddr,
  input  logic [31:0] csr_rddata,
  input  logic [31:0] csr_mstatus,
  input  logic [31:0] csr_mepc,
  output logic        EX_mepc_vld,
  output logic [31:0] EX_mepc,
  output logic        EX_mcause_vld,
  output logic [31:0] EX_mcause,
  output logic        EX_mstatus_vld,
  output logic [31:0] EX_mstatus,
  output logic        hold,
  output logic        jump_en,
  output logic [31:0] jump_addr
);

  trap_state_e state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] cause_q, cause_d;
  logic        flush_q;
  logic        irq_timer_s, irq_ext_s;
  logic        trap_instr, irq_ok;
  logic        take;
  logic [31:0] take_cause;
  logic [31:0] mtvec_base, jump_target;

  irq_sync #(.N(IRQ_SYNC_STAGES)) u_sync_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (irq_timer),
    .q     (irq_timer_s)
  );

  irq_sync #(.N(IRQ_SYNC_STAGES)) u_sync_ext (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (irq_ext),
    .q     (irq_ext_s)
  );

  assign trap_instr = ex_ecall | ex_ebreak | ex_mret;
  assign irq_ok     = csr_mstatus[MSTATUS_MIE] & ~trap_instr;
  assign mtvec_base = {csr_rddata[31:2], 2'b00};

  // irq_ok already excludes mret, so mret only loses to ecall/ebreak
  always_comb begin : trap_select
    take       = 1'b0;
    take_cause = '0;
    if (ex_ecall) begin
      take       = 1'b1;
      take_cause = CAUSE_ECALL;
    end else if (ex_ebreak) begin
      take       = 1'b1;
      take_cause = CAUSE_EBREAK;
    end else if (irq_ok && irq_ext_s) begin
      take       = 1'b1;
      take_cause = CAUSE_IRQ_EXT;
    end else if (irq_ok && irq_timer_s) begin
      take       = 1'b1;
      take_cause = CAUSE_IRQ_TIMER;
    end
  end

`ifdef TRAP_VECTORED_EN
  always_comb begin : target_sel
    jump_target = mtvec_base;
    if (csr_rddata[1:0] == 2'b01 && cause_q[31]) begin
      jump_target = mtvec_base + {26'd0, cause_q[3:0], 2'b00};
    end
  end
`else
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^csr_rddata[1:0];
  assign jump_target       = mtvec_base;
`endif

  always_comb begin : fsm_comb
    state_d        = state_q;
    pc_d           = pc_q;
    cause_d        = cause_q;
    hold           = 1'b0;
    jump_en        = 1'b0;
    jump_addr      = '0;
    csr_rdaddr     = ex_csr_rdaddr;
    EX_mepc_vld    = 1'b0;
    EX_mepc        = '0;
    EX_mcause_vld  = 1'b0;
    EX_mcause      = '0;
    EX_mstatus_vld = 1'b0;
    EX_mstatus     = '0;
    if (rst_n) begin
      case (state_q)
        ST_IDLE: begin
          // the cycle after a jump only sees instructions that are being flushed
          if (!flush_q) begin
            if (take) begin
              hold    = 1'b1;
              pc_d    = ex_pc;
              cause_d = take_cause;
              state_d = ST_RD_MTVEC;
            end else if (ex_mret) begin
              hold    = 1'b1;
              state_d = ST_MRET;
            end
          end
        end
        ST_RD_MTVEC: begin
          csr_rdaddr = CSR_MTVEC;
          hold       = 1'b1;
          state_d    = ST_COMMIT;
        end
        ST_COMMIT: begin
          csr_rdaddr     = CSR_MTVEC;
          hold           = 1'b1;
          EX_mepc_vld    = 1'b1;
          EX_mepc        = pc_q;
          EX_mcause_vld  = 1'b1;
          EX_mcause      = cause_q;
          EX_mstatus_vld = 1'b1;
          EX_mstatus     = mstatus_on_trap(csr_mstatus);
          jump_en        = 1'b1;
          jump_addr      = jump_target;
          state_d        = ST_IDLE;
        end
        ST_MRET: begin
          hold           = 1'b1;
          EX_mstatus_vld = 1'b1;
          EX_mstatus     = mstatus_on_mret(csr_mstatus);
          jump_en        = 1'b1;
          jump_addr      = csr_mepc;
          state_d        = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      cause_q <= '0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cause_q <= cause_d;
      flush_q <= jump_en;
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed scenarios then randomized traffic,
// all against a queue-based reference model and a small CSR file model.
module tb_trap_ctrl;

  localparam int unsigned SYNC     = 2;
  localparam int unsigned N_RANDOM = 3000;
`ifdef TRAP_VECTORED_EN
  localparam logic [31:0] VEC_TIMER_EXP = 32'h21C;
`else
  localparam logic [31:0] VEC_TIMER_EXP = 32'h200;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, ex_ecall, ex_ebreak, ex_mret, irq_timer, irq_ext;
  logic [31:0] ex_pc, csr_rddata, csr_mstatus, csr_mepc;
  logic [11:0] ex_csr_rdaddr, csr_rdaddr;
  logic        EX_mepc_vld, EX_mcause_vld, EX_mstatus_vld, hold, jump_en;
  logic [31:0] EX_mepc, EX_mcause, EX_mstatus, jump_addr;
  logic [31:0] mtvec;

  trap_ctrl #(.IRQ_SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_ecall(ex_ecall), .ex_ebreak(ex_ebreak), .ex_mret(ex_mret), .ex_pc(ex_pc),
    .irq_timer(irq_timer), .irq_ext(irq_ext),
    .ex_csr_rdaddr(ex_csr_rdaddr), .csr_rdaddr(csr_rdaddr), .csr_rddata(csr_rddata),
    .csr_mstatus(csr_mstatus), .csr_mepc(csr_mepc),
    .EX_mepc_vld(EX_mepc_vld), .EX_mepc(EX_mepc),
    .EX_mcause_vld(EX_mcause_vld), .EX_mcause(EX_mcause),
    .EX_mstatus_vld(EX_mstatus_vld), .EX_mstatus(EX_mstatus),
    .hold(hold), .jump_en(jump_en), .jump_addr(jump_addr)
  );

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a taken event schedules the outputs of the following cycles.
  typedef enum {OP_RD, OP_COMMIT, OP_MRET} op_e;
  op_e         ops[$];
  logic [31:0] m_pc, m_cause;
  bit          m_flush;
  bit          t_hist[$], x_hist[$];
  bit          g_tmr, g_ext;

  logic        e_hold, e_jen, e_mepc_vld, e_mcause_vld, e_mstatus_vld, e_rd_chk;
  logic [31:0] e_jaddr, e_mepc, e_mcause, e_mstatus;
  logic [11:0] e_rd;
  logic        o_hold, o_jen, o_vld_any;
  logic [31:0] o_jaddr, o_mepc, o_mcause, o_mstatus;
  logic [11:0] o_rd;

  function automatic logic [31:0] trap_mstatus(input logic [31:0] s);
    return (s & ~32'h0000_1888) | (((s >> 3) & 32'd1) << 7) | 32'h0000_1800;
  endfunction

  function automatic logic [31:0] mret_mstatus(input logic [31:0] s);
    return (s & ~32'h0000_0088) | (((s >> 7) & 32'd1) << 3) | 32'h0000_0080;
  endfunction

  function automatic logic [31:0] trap_target(input logic [31:0] tv, input logic [31:0] cause);
    logic [31:0] t;
    t = tv & ~32'd3;
`ifdef TRAP_VECTORED_EN
    if ((tv & 32'd3) == 32'd1 && cause[31]) t = t + 32'd4 * (cause & 32'd15);
`endif
    return t;
  endfunction

  task automatic model_eval();
    op_e         op;
    bit          ts, xs, irq_ok, tk;
    logic [31:0] c;
    e_hold = 0; e_jen = 0; e_jaddr = '0; e_rd = ex_csr_rdaddr; e_rd_chk = 1;
    e_mepc_vld = 0; e_mcause_vld = 0; e_mstatus_vld = 0;
    e_mepc = '0; e_mcause = '0; e_mstatus = '0;
    t_hist.push_front(irq_timer);
    x_hist.push_front(irq_ext);
    ts = t_hist[SYNC];
    xs = x_hist[SYNC];
    if (rst_n) begin
      if (ops.size() != 0) begin
        op = ops.pop_front();
        e_hold = 1;
        case (op)
          OP_RD: e_rd = 12'h305;
          OP_COMMIT: begin
            e_rd_chk = 0;
            e_mepc_vld = 1; e_mcause_vld = 1; e_mstatus_vld = 1;
            e_mepc = m_pc; e_mcause = m_cause; e_mstatus = trap_mstatus(csr_mstatus);
            e_jen = 1; e_jaddr = trap_target(mtvec, m_cause);
          end
          default: begin
            e_mstatus_vld = 1; e_mstatus = mret_mstatus(csr_mstatus);
            e_jen = 1; e_jaddr = csr_mepc;
          end
        endcase
      end else if (!m_flush) begin
        irq_ok = csr_mstatus[3] && !(ex_ecall || ex_ebreak || ex_mret);
        tk = 1; c = '0;
        if (ex_ecall) c = 32'd11;
        else if (ex_ebreak) c = 32'd3;
        else if (ex_mret) begin
          tk = 0; e_hold = 1; ops.push_back(OP_MRET);
        end
        else if (irq_ok && xs) c = 32'h8000_000B;
        else if (irq_ok && ts) c = 32'h8000_0007;
        else tk = 0;
        if (tk) begin
          e_hold = 1; m_pc = ex_pc; m_cause = c;
          ops.push_back(OP_RD);
          ops.push_back(OP_COMMIT);
        end
      end
    end
  endtask

  task automatic model_advance();
    csr_rddata = (o_rd == 12'h305) ? mtvec : {20'h0, o_rd};
    if (!rst_n) begin
      ops.delete();
      m_flush = 0;
      foreach (t_hist[i]) t_hist[i] = 0;
      foreach (x_hist[i]) x_hist[i] = 0;
    end else begin
      m_flush = e_jen;
      if (e_mepc_vld) csr_mepc = e_mepc;
      if (e_mstatus_vld) csr_mstatus = e_mstatus;
    end
    void'(t_hist.pop_back());
    void'(x_hist.pop_back());
  endtask

  task automatic step(input bit rst, ec, eb, mr, input logic [31:0] pc,
                      input bit tmr, ext, input logic [11:0] rda);
    @(negedge clk);
    rst_n = rst; ex_ecall = ec; ex_ebreak = eb; ex_mret = mr; ex_pc = pc;
    irq_timer = tmr; irq_ext = ext; ex_csr_rdaddr = rda;
    #1;
    model_eval();
    check("hold", hold, e_hold);
    check("jump_en", jump_en, e_jen);
    check("mepc_vld", EX_mepc_vld, e_mepc_vld);
    check("mcause_vld", EX_mcause_vld, e_mcause_vld);
    check("mstatus_vld", EX_mstatus_vld, e_mstatus_vld);
    if (e_rd_chk) check("csr_rdaddr", csr_rdaddr, e_rd);
    if (e_jen) check("jump_addr", jump_addr, e_jaddr);
    if (e_mepc_vld) check("EX_mepc", EX_mepc, e_mepc);
    if (e_mcause_vld) check("EX_mcause", EX_mcause, e_mcause);
    if (e_mstatus_vld) check("EX_mstatus", EX_mstatus, e_mstatus);
    o_hold = hold; o_jen = jump_en; o_jaddr = jump_addr; o_rd = csr_rdaddr;
    o_mepc = EX_mepc; o_mcause = EX_mcause; o_mstatus = EX_mstatus;
    o_vld_any = EX_mepc_vld | EX_mcause_vld | EX_mstatus_vld;
    @(posedge clk);
    #1;
    model_advance();
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1, 0, 0, 0, 32'h0, g_tmr, g_ext, 12'h340);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; ex_ecall = 0; ex_ebreak = 0; ex_mret = 0; ex_pc = '0;
    irq_timer = 0; irq_ext = 0; ex_csr_rdaddr = '0; csr_rddata = '0;
    csr_mstatus = 32'h8; csr_mepc = '0; mtvec = 32'h100;
    g_tmr = 0; g_ext = 0; m_flush = 0; m_pc = '0; m_cause = '0;
    for (int unsigned i = 0; i <= SYNC; i++) begin
      t_hist.push_back(0);
      x_hist.push_back(0);
    end

    repeat (3) step(0, 0, 0, 0, 32'h0, 0, 0, 12'h340);
    check("rst_hold", o_hold, 0);
    check("rst_jump_en", o_jen, 0);
    check("rst_vld", o_vld_any, 0);
    idle(1);
    check("idle_rdaddr", o_rd, 12'h340);
    check("post_rst_mepc", o_mepc, 0);
    check("post_rst_mcause", o_mcause, 0);
    check("post_rst_jaddr", o_jaddr, 0);

    // ecall: hold three cycles, jump on the third
    step(1, 1, 0, 0, 32'h40, 0, 0, 12'h340);
    check("ecall_hold0", o_hold, 1);
    idle(1);
    check("rd_mtvec_addr", o_rd, 12'h305);
    check("ecall_hold1", o_hold, 1);
    check("ecall_early_jump", o_jen, 0);
    idle(1);
    check("ecall_jump_en", o_jen, 1);
    check("ecall_jaddr", o_jaddr, 32'h100);
    check("ecall_mepc", o_mepc, 32'h40);
    check("ecall_mcause", o_mcause, 32'd11);
    check("ecall_mstatus", o_mstatus, 32'h1880);
    check("ecall_hold2", o_hold, 1);
    idle(1);
    check("ecall_hold_drop", o_hold, 0);

    csr_mepc = 32'h44;
    step(1, 0, 0, 1, 32'h48, 0, 0, 12'h340);
    check("mret_hold0", o_hold, 1);
    check("mret_early_jump", o_jen, 0);
    idle(1);
    check("mret_jump_en", o_jen, 1);
    check("mret_jaddr", o_jaddr, 32'h44);
    check("mret_mstatus", o_mstatus, 32'h1888);
    idle(1);
    check("mret_hold_drop", o_hold, 0);

    // timer irq through the 2-stage synchronizer, then held with MIE cleared
    g_tmr = 1;
    idle(1); check("tmr_sync0", o_hold, 0);
    idle(1); check("tmr_sync1", o_hold, 0);
    idle(1); check("tmr_taken", o_hold, 1);
    idle(2);
    check("tmr_jump_en", o_jen, 1);
    check("tmr_mcause", o_mcause, 32'h8000_0007);
    idle(4);
    check("tmr_mie0_hold", o_hold, 0);
    g_tmr = 0;
    idle(3);

    // ebreak beats both irqs; ext follows once MIE is re-enabled
    csr_mstatus = 32'h8; g_tmr = 1; g_ext = 1;
    idle(2);
    step(1, 0, 1, 0, 32'h80, 1, 1, 12'h340);
    check("ebreak_hold", o_hold, 1);
    idle(2);
    check("ebreak_mcause", o_mcause, 32'd3);
    check("ebreak_jaddr", o_jaddr, 32'h100);
    idle(1);
    csr_mstatus = 32'h1888;
    idle(1);
    check("ext_taken", o_hold, 1);
    idle(2);
    check("ext_mcause", o_mcause, 32'h8000_000B);
    g_tmr = 0; g_ext = 0;
    idle(3);

    mtvec = 32'h201; csr_mstatus = 32'h8; g_tmr = 1;
    idle(5);
    check("vec_timer_jen", o_jen, 1);
    check("vec_timer_jaddr", o_jaddr, VEC_TIMER_EXP);
    g_tmr = 0;
    idle(2);
    step(1, 1, 0, 0, 32'h90, 0, 0, 12'h340);
    idle(2);
    check("vec_ecall_jaddr", o_jaddr, 32'h200);
    idle(1);

    // reset during the mtvec read aborts the sequence
    mtvec = 32'h100;
    step(1, 1, 0, 0, 32'hA0, 0, 0, 12'h340);
    step(0, 0, 0, 0, 32'h0, 0, 0, 12'h340);
    check("rst_mid_vld", o_vld_any, 0);
    idle(1);
    check("rst_abort_vld", o_vld_any, 0);
    check("rst_abort_jump", o_jen, 0);
    check("rst_abort_hold", o_hold, 0);

    for (int unsigned c = 0; c < N_RANDOM; c++) begin
      bit r, ec, eb, mr;
      r  = ($urandom_range(0, 199) != 0);
      ec = ($urandom_range(0, 15) == 0);
      eb = ($urandom_range(0, 15) == 0);
      mr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) g_tmr = ~g_tmr;
      if ($urandom_range(0, 7) == 0) g_ext = ~g_ext;
      step(r, ec, eb, mr, $urandom & ~32'd3, g_tmr, g_ext, 12'($urandom));
      if (!e_mstatus_vld && $urandom_range(0, 9) == 0) csr_mstatus = $urandom;
      if (!e_mepc_vld && $urandom_range(0, 19) == 0) csr_mepc = $urandom;
      if (ops.size() == 0 && $urandom_range(0, 19) == 0)
        mtvec = ($urandom & ~32'd3) | 32'($urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
